// File: rtl/digit_serial_multiplier_pkg.sv
// Shared definitions for the digit-serial multiplier.
// - Controller state encoding (legacy-compatible localparam constants).
// - Helpers for digit counts and product width.
// - Parameter legality check, evaluated by the top at elaboration.
package mult_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StSign = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  function automatic int unsigned prod_width(input int unsigned width_a,
                                             input int unsigned width_b);
    return width_a + width_b;
  endfunction

  function automatic bit widths_legal(input int unsigned width_a, input int unsigned width_b,
                                      input int unsigned digit);
    return (digit > 0) && (width_a >= digit) && (width_b >= digit) &&
           (width_a % digit == 0) && (width_b % digit == 0);
  endfunction

endpackage

// File: rtl/digit_serial_multiplier_if.sv
// Request/response bundle of the digit-serial multiplier.
// - start, is_signed, a, b : request, driven by the master, sampled by the unit in IDLE.
// - busy, done, product    : status and result, driven by the unit (slave).
interface digit_serial_multiplier_if
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH_A = 8,
  parameter int unsigned WIDTH_B = 8
);

  localparam int unsigned PW = prod_width(WIDTH_A, WIDTH_B);

  logic               start;
  logic               is_signed;
  logic [WIDTH_A-1:0] a;
  logic [WIDTH_B-1:0] b;
  logic               busy;
  logic               done;
  logic [PW-1:0]      product;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/digit_serial_multiplier_digit_multiplier.sv
// Combinational DIGIT x DIGIT unsigned multiplier.
// - x, y : unsigned digits
// - p    : full 2*DIGIT-bit product
module digit_multiplier #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0]   x,
  input  logic [DIGIT-1:0]   y,
  output logic [2*DIGIT-1:0] p
);

  assign p = {{DIGIT{1'b0}}, x} * {{DIGIT{1'b0}}, y};

endmodule

// File: rtl/digit_serial_multiplier.sv
// Digit-serial multiplier: one DIGIT x DIGIT partial product per cycle on operand magnitudes,
// sign applied once at the end. Zero operands skip straight to DONE.
// - clk : rising-edge clock
// - rst : synchronous active-low reset
// - bus : slave side of the request/response bundle (start/is_signed/a/b in,
//         busy/done/product out)
module digit_serial_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH_A = 8,
  parameter int unsigned WIDTH_B = 8,
  parameter int unsigned DIGIT   = 2
) (
  input logic                      clk,
  input logic                      rst,
  digit_serial_multiplier_if.slave bus
);

  localparam int unsigned NA = num_digits(WIDTH_A, DIGIT);
  localparam int unsigned NB = num_digits(WIDTH_B, DIGIT);
  localparam int unsigned PW = prod_width(WIDTH_A, WIDTH_B);
  localparam int unsigned IW = (NA > 1) ? $clog2(NA) : 1;
  localparam int unsigned JW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] ILast = IW'(NA - 1);
  localparam logic [JW-1:0] JLast = JW'(NB - 1);

  if (!widths_legal(WIDTH_A, WIDTH_B, DIGIT)) begin : g_bad_params
    $error("digit_serial_multiplier: WIDTH_A and WIDTH_B must be non-zero multiples of DIGIT");
  end

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      i_q, i_d;
  logic [JW-1:0]      j_q, j_d;
  logic [WIDTH_A-1:0] a_mag_q, a_mag_d;
  logic [WIDTH_B-1:0] b_mag_q, b_mag_d;
  logic               neg_q, neg_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      product_q, product_d;

  // Most-negative input negates to 2^(W-1), which is still correct read as unsigned.
  logic               a_neg_in, b_neg_in;
  logic [WIDTH_A-1:0] a_mag_in;
  logic [WIDTH_B-1:0] b_mag_in;

  assign a_neg_in = bus.is_signed & bus.a[WIDTH_A-1];
  assign b_neg_in = bus.is_signed & bus.b[WIDTH_B-1];
  assign a_mag_in = a_neg_in ? -bus.a : bus.a;
  assign b_mag_in = b_neg_in ? -bus.b : bus.b;

  logic [DIGIT-1:0]   a_dig, b_dig;
  logic [2*DIGIT-1:0] pp;
  logic [PW-1:0]      pp_shift, acc_base;

  assign a_dig = a_mag_q[i_q*DIGIT +: DIGIT];
  assign b_dig = b_mag_q[j_q*DIGIT +: DIGIT];

  digit_multiplier #(
    .DIGIT(DIGIT)
  ) u_digit_multiplier (
    .x(a_dig),
    .y(b_dig),
    .p(pp)
  );

  // Horner over A digits: each new A digit starts by scaling the running sum by 2^DIGIT.
  assign pp_shift = PW'(pp) << (DIGIT * j_q);
  assign acc_base = (j_q == JLast) ? (acc_q << DIGIT) : acc_q;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_mag_d = a_mag_in;
          b_mag_d = b_mag_in;
          neg_d   = bus.is_signed & (bus.a[WIDTH_A-1] ^ bus.b[WIDTH_B-1]);
          acc_d   = '0;
          if ((bus.a == '0) || (bus.b == '0)) begin
            product_d = '0;
            state_d   = StDone;
          end else begin
            i_d     = ILast;
            j_d     = JLast;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = acc_base + pp_shift;
        if (j_q == '0) begin
          j_d = JLast;
          if (i_q == '0) begin
            state_d = StSign;
          end else begin
            i_d = i_q - 1'b1;
          end
        end else begin
          j_d = j_q - 1'b1;
        end
      end
      StSign: begin
        product_d = neg_q ? -acc_q : acc_q;
        state_d   = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      i_q       <= '0;
      j_q       <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);
  assign bus.product = product_q;

endmodule

// File: tb/tb_digit_serial_multiplier.sv
// Scoreboard bench for digit_serial_multiplier: an 8x8/D2 instance and a 4x4/D2 instance.
// Drivers push the reference result and expected done cycle; monitors pop on done.
module tb_digit_serial_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst4;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] prod;
    int          at;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  digit_serial_multiplier_if #(.WIDTH_A(8), .WIDTH_B(8)) b8 ();
  digit_serial_multiplier_if #(.WIDTH_A(4), .WIDTH_B(4)) b4 ();

  digit_serial_multiplier #(.WIDTH_A(8), .WIDTH_B(8), .DIGIT(2)) dut8 (
    .clk(clk),
    .rst(rst8),
    .bus(b8)
  );

  digit_serial_multiplier #(.WIDTH_A(4), .WIDTH_B(4), .DIGIT(2)) dut4 (
    .clk(clk),
    .rst(rst4),
    .bus(b4)
  );

  // Reference: plain integer multiplication of the interpreted operands, truncated.
  function automatic logic [15:0] ref8(input bit s, input logic [7:0] a, input logic [7:0] b);
    longint x, y, p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[15:0];
  endfunction

  function automatic logic [7:0] ref4(input bit s, input logic [3:0] a, input logic [3:0] b);
    longint x, y, p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (b8.done === 1'b1) begin
      total++;
      if (q8.size() == 0) begin
        bad++;
        $display("FAIL dut8 unexpected done: actual product=%0h required=no done", b8.product);
      end else begin
        e = q8.pop_front();
        check("dut8 product", 32'(b8.product), 32'(e.prod));
        check("dut8 done cycle", cyc, e.at);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (b4.done === 1'b1) begin
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL dut4 unexpected done: actual product=%0h required=no done", b4.product);
      end else begin
        e = q4.pop_front();
        check("dut4 product", 32'(b4.product), 32'(e.prod));
        check("dut4 done cycle", cyc, e.at);
      end
    end
  end

  // Issue one request; k is the cycle in which start is sampled (cycle 0).
  task automatic issue8(input bit s, input logic [7:0] a, input logic [7:0] b, output int k);
    exp_t e;
    @(negedge clk);
    k = cyc;
    b8.start     = 1'b1;
    b8.is_signed = s;
    b8.a         = a;
    b8.b         = b;
    e.prod = ref8(s, a, b);
    e.at   = k + (((a == 0) || (b == 0)) ? 1 : 18);
    q8.push_back(e);
    @(negedge clk);
    b8.start     = 1'b0;
    b8.a         = 8'($urandom);
    b8.b         = 8'($urandom);
    b8.is_signed = 1'($urandom);
  endtask

  task automatic issue4(input bit s, input logic [3:0] a, input logic [3:0] b, output int k);
    exp_t e;
    @(negedge clk);
    k = cyc;
    b4.start     = 1'b1;
    b4.is_signed = s;
    b4.a         = a;
    b4.b         = b;
    e.prod = {8'h00, ref4(s, a, b)};
    e.at   = k + (((a == 0) || (b == 0)) ? 1 : 6);
    q4.push_back(e);
    @(negedge clk);
    b4.start     = 1'b0;
    b4.a         = 4'($urandom);
    b4.b         = 4'($urandom);
    b4.is_signed = 1'($urandom);
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (b8.busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("dut8 idle within bound", 32'(n < 100), 32'(1));
  endtask

  task automatic wait_idle4();
    int n = 0;
    while (b4.busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("dut4 idle within bound", 32'(n < 100), 32'(1));
  endtask

  initial begin
    int k, first, last;
    bit s;
    logic [7:0] a8, bb8;
    logic [3:0] a4, bb4;

    b8.start = 1'b0; b8.is_signed = 1'b0; b8.a = '0; b8.b = '0;
    b4.start = 1'b0; b4.is_signed = 1'b0; b4.a = '0; b4.b = '0;
    rst8 = 1'b0;
    rst4 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy8", 32'(b8.busy), 0);
    check("reset done8", 32'(b8.done), 0);
    check("reset product8", 32'(b8.product), 0);
    check("reset busy4", 32'(b4.busy), 0);
    check("reset product4", 32'(b4.product), 0);
    rst8 = 1'b1;
    rst4 = 1'b1;

    // 13*11 with busy window measured relative to the accept cycle.
    issue8(1'b0, 8'd13, 8'd11, k);
    first = -1;
    last  = -1;
    repeat (22) begin
      if (b8.busy === 1'b1) begin
        if (first < 0) first = cyc - k;
        last = cyc - k;
      end
      @(negedge clk);
    end
    check("busy first cycle", first, 1);
    check("busy last cycle", last, 18);

    issue8(1'b0, 8'd255, 8'd255, k); wait_idle8();
    issue8(1'b1, 8'hFD, 8'd5, k);    wait_idle8();
    issue8(1'b1, 8'h80, 8'h80, k);   wait_idle8();
    issue8(1'b1, 8'h80, 8'h7F, k);   wait_idle8();
    issue8(1'b0, 8'd0, 8'd200, k);   wait_idle8();
    issue8(1'b0, 8'd7, 8'd9, k);     wait_idle8();

    // Starts at cycle 5 (CALC) and cycle 18 (DONE) must be ignored.
    issue8(1'b0, 8'd13, 8'd11, k);
    repeat (4) @(negedge clk);
    b8.start = 1'b1; b8.a = 8'd99; b8.b = 8'd3; b8.is_signed = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (12) @(negedge clk);
    check("cycle before stray start", cyc - k, 18);
    b8.start = 1'b1; b8.a = 8'd200; b8.b = 8'd201; b8.is_signed = 1'b0;
    @(negedge clk);
    b8.start = 1'b0;
    check("stray start in DONE ignored", 32'(b8.busy), 0);
    check("product held after op", 32'(b8.product), 32'd143);

    // Reset at cycle 8 aborts; no done pulse may follow.
    issue8(1'b0, 8'd200, 8'd3, k);
    repeat (7) @(negedge clk);
    rst8 = 1'b0;
    @(negedge clk);
    void'(q8.pop_back());
    check("abort busy", 32'(b8.busy), 0);
    check("abort done", 32'(b8.done), 0);
    check("abort product", 32'(b8.product), 0);
    rst8 = 1'b1;
    repeat (25) @(negedge clk);
    issue8(1'b1, 8'hF9, 8'd9, k); wait_idle8();

    // Random sweep, zero operands included.
    for (int n = 0; n < 40; n++) begin
      s   = 1'($urandom);
      a8  = ($urandom_range(7, 0) == 0) ? 8'd0 : 8'($urandom);
      bb8 = ($urandom_range(7, 0) == 0) ? 8'd0 : 8'($urandom);
      issue8(s, a8, bb8, k);
      wait_idle8();
    end

    issue4(1'b0, 4'd15, 4'd15, k); wait_idle4();
    issue4(1'b1, 4'h8, 4'h8, k);   wait_idle4();
    for (int n = 0; n < 30; n++) begin
      s   = 1'($urandom);
      a4  = 4'($urandom);
      bb4 = 4'($urandom);
      issue4(s, a4, bb4, k);
      wait_idle4();
    end

    repeat (5) @(negedge clk);
    check("dut8 all results seen", q8.size(), 0);
    check("dut4 all results seen", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
